// File: rtl/seq_shift_unit_if.sv
// Handshake and data bundle for seq_shift_unit.
//
// Both sides use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both high. A source that has raised
// valid keeps valid and its payload unchanged until that edge. Ready may rise
// or fall at any time, and a source never waits for ready before raising
// valid.
interface seq_shift_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             zero;

   // Requester and result consumer side.
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, out, carry, zero
   );

   // Shift unit side.
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, out, carry, zero
   );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: SLL, SRL, SRA and ROL, one bit position per
// clock. It accepts a request in IDLE, steps in SHIFT, and holds the result in
// DONE until the consumer takes it. The FSM state goes out on state_dbg
// (0 IDLE, 1 SHIFT, 2 DONE).
module seq_shift_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_shift_unit_if.slave    bus,
   output logic [1:0]         state_dbg
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] w;         // working operand, shown as out
   logic [1:0]       mode;      // operation captured at acceptance
   logic [CNT_W-1:0] cnt;       // steps still to perform
   logic             carry_r;   // last bit shifted or rotated out
   logic             zero_r;    // out == 0, updated together with out

   logic             accept;
   logic             last_step;
   logic [CNT_W-1:0] load_cnt;
   logic [WIDTH-1:0] w_step;
   logic             c_step;

   assign accept    = (state == S_IDLE) && bus.in_valid;
   assign last_step = (cnt == {{(CNT_W-1){1'b0}}, 1'b1});

   // Step count for a new request. Shifts saturate at WIDTH, because any larger
   // amount gives the same result and carry. Rotates use the amount modulo
   // WIDTH. WIDTH is a power of two, so b >= WIDTH exactly when a bit at or
   // above position SH_W is set.
   always_comb begin
      load_cnt = {1'b0, bus.b[SH_W-1:0]};
      if ((bus.op != OP_ROL) && (|bus.b[WIDTH-1:SH_W])) begin
         load_cnt = CNT_W'(WIDTH);
      end
   end

   // One 1-bit step of the captured operation applied to the working register.
   always_comb begin
      w_step = w;
      c_step = 1'b0;
      case (mode)
         OP_SLL: begin
            c_step = w[WIDTH-1];
            w_step = {w[WIDTH-2:0], 1'b0};
         end
         OP_SRL: begin
            c_step = w[0];
            w_step = {1'b0, w[WIDTH-1:1]};
         end
         OP_SRA: begin
            c_step = w[0];
            w_step = {w[WIDTH-1], w[WIDTH-1:1]};
         end
         default: begin
            c_step = w[WIDTH-1];
            w_step = {w[WIDTH-2:0], w[WIDTH-1]};
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A zero step count goes straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_nxt = (load_cnt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_step) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs come from the state alone. While a result is held,
   // nothing is accepted.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         S_IDLE:  bus.in_ready  = 1'b1;
         S_DONE:  bus.out_valid = 1'b1;
         default: begin
            bus.in_ready  = 1'b0;
            bus.out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: capture on acceptance, step in SHIFT, hold everything in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         w       <= '0;
         mode    <= OP_SLL;
         cnt     <= '0;
         carry_r <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  w       <= bus.a;
                  mode    <= bus.op;
                  cnt     <= load_cnt;
                  carry_r <= 1'b0;
                  zero_r  <= (load_cnt == '0) && (bus.a == '0);
               end
            end
            S_SHIFT: begin
               w       <= w_step;
               carry_r <= c_step;
               cnt     <= cnt - 1'b1;
               if (last_step) begin
                  zero_r <= (w_step == '0);
               end
            end
            default: begin
               // DONE: result and flags are held until consumed.
            end
         endcase
      end
   end

   assign bus.out    = w;
   assign bus.carry  = carry_r;
   assign bus.zero   = zero_r;
   assign state_dbg  = state;

   // A held result must not change while the consumer stalls.
   a_done_hold: assert property (@(posedge clk) disable iff (rst)
      (state == S_DONE && !bus.out_ready) |=>
         (state == S_DONE && $stable(w) && $stable(carry_r) && $stable(zero_r)));

   // Consuming a result always returns the unit to IDLE.
   a_done_exit: assert property (@(posedge clk) disable iff (rst)
      (state == S_DONE && bus.out_ready) |=> (state == S_IDLE));

   // SHIFT is only ever occupied with work remaining.
   a_shift_cnt: assert property (@(posedge clk) disable iff (rst)
      (state == S_SHIFT) |-> (cnt != '0));

   // The zero flag matches the result whenever the result is offered.
   a_zero_flag: assert property (@(posedge clk) disable iff (rst)
      (state == S_DONE) |-> (zero_r == (w == '0)));

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=8). The reference model computes
// each result from the whole shift amount with wide arithmetic. Directed cases,
// a backpressure window, a mid-operation reset and random traffic run through
// one scoreboard.
module tb_seq_shift_unit;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] state_dbg;
   int   cyc = 0;

   always #5 clk = ~clk;

   // Cycle counter, used to measure latency from the acceptance edge.
   always @(posedge clk) cyc <= cyc + 1;

   seq_shift_unit_if #(.WIDTH(W)) bus();

   seq_shift_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Scoreboard: one entry per accepted request.
   logic [W-1:0] exp_q[$];
   logic         exp_c_q[$];
   logic         exp_z_q[$];
   int           exp_lat_q[$];
   int           acc_q[$];

   bit mon_en = 1'b0;
   bit hold   = 1'b1;   // forces out_ready low
   bit rnd    = 1'b0;   // randomises out_ready
   bit have_cur = 1'b0;
   bit was_taken = 1'b0;
   logic [W-1:0] cur_out;
   logic         cur_c;
   logic         cur_z;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model computed from the whole shift amount at once.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        output logic [W-1:0] o, output logic c, output logic z, output int lat);
      int n;
      logic [2*W-1:0] full;
      if (op == 2'b11) n = int'(b) % W;
      else             n = (int'(b) >= W) ? W : int'(b);
      o = a;
      c = 1'b0;
      case (op)
         2'b00: begin
            full = {{W{1'b0}}, a} << n;
            o = full[W-1:0];
            c = (n != 0) ? full[W] : 1'b0;
         end
         2'b01: begin
            full = {a, {W{1'b0}}} >> n;
            o = full[2*W-1:W];
            c = (n != 0) ? full[W-1] : 1'b0;
         end
         2'b10: begin
            full = $signed({a, {W{1'b0}}}) >>> n;
            o = full[2*W-1:W];
            c = (n != 0) ? full[W-1] : 1'b0;
         end
         default: begin
            if (n != 0) begin
               o = (a << n) | (a >> (W - n));
               c = o[0];
            end
         end
      endcase
      z = (o == '0);
      lat = n + 1;
   endtask

   // Driver: call at a negedge. Holds the request until it is accepted, then
   // records the expected result.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      int waited = 0;
      logic [W-1:0] o;
      logic c, z;
      int lat;
      bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         n_vec++; n_bad++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      end else begin
         model(a, b, op, o, c, z, lat);
         exp_q.push_back(o); exp_c_q.push_back(c); exp_z_q.push_back(z);
         exp_lat_q.push_back(lat); acc_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op = 2'($urandom);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || have_cur || bus.out_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k == 200) begin
         n_vec++; n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
   endtask

   // Compare process. It checks every cycle a result is offered and the cycle
   // after one is taken, then chooses out_ready for the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (was_taken) begin
            check("valid_after_take", bus.out_valid, 0);
            check("ready_after_take", bus.in_ready, 1);
            was_taken = 1'b0;
         end else if (bus.out_valid) begin
            if (!have_cur) begin
               if (exp_q.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL unexpected_result: out_valid=1 with nothing accepted, out=%0h", bus.out);
               end else begin
                  cur_out = exp_q.pop_front();
                  cur_c   = exp_c_q.pop_front();
                  cur_z   = exp_z_q.pop_front();
                  check("latency", cyc - acc_q.pop_front() + 1, exp_lat_q.pop_front());
                  have_cur = 1'b1;
               end
            end
            if (have_cur) begin
               check("out", bus.out, cur_out);
               check("carry", bus.carry, cur_c);
               check("zero", bus.zero, cur_z);
               check("in_ready_in_done", bus.in_ready, 0);
            end
         end
      end
      bus.out_ready = hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (mon_en && bus.out_valid && bus.out_ready) begin
         have_cur  = 1'b0;
         was_taken = 1'b1;
      end
   end

   initial begin
      logic [W-1:0] o;
      logic c, z;
      int lat;
      int k;

      // Clock/reset.
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out", bus.out, 0);
      check("rst_carry", bus.carry, 0);
      check("rst_zero", bus.zero, 0);

      // Hand-computed values that pin the reference model.
      model(8'h90, 8'd3, 2'b10, o, c, z, lat);
      check("model_sra_90_3", {o, c}, {8'hF2, 1'b0});
      model(8'h80, 8'd200, 2'b10, o, c, z, lat);
      check("model_sra_80_200", {o, c, 24'(lat)}, {8'hFF, 1'b1, 24'd9});
      model(8'h81, 8'd9, 2'b11, o, c, z, lat);
      check("model_rol_81_9", {o, c, 24'(lat)}, {8'h03, 1'b1, 24'd2});
      model(8'hB3, 8'd255, 2'b00, o, c, z, lat);
      check("model_sll_sat", {o, c, z}, {8'h00, 1'b1, 1'b1});

      // Directed requests through the DUT.
      mon_en = 1'b1;
      hold   = 1'b0;
      @(negedge clk); issue(8'h90, 8'd3,   2'b10);
      @(negedge clk); issue(8'h80, 8'd200, 2'b10);
      @(negedge clk); issue(8'h81, 8'd9,   2'b11);
      @(negedge clk); issue(8'h5A, 8'd0,   2'b01);
      @(negedge clk); issue(8'hB3, 8'd8,   2'b00);
      @(negedge clk); issue(8'hB3, 8'd255, 2'b00);
      @(negedge clk); issue(8'h00, 8'd0,   2'b00);
      @(negedge clk); issue(8'h80, 8'd7,   2'b01);
      @(negedge clk); issue(8'h3C, 8'd8,   2'b11);
      drain();

      // Backpressure. Hold the result for 5 cycles and pulse a request that
      // must be ignored.
      hold = 1'b1;
      @(negedge clk); issue(8'hC5, 8'd2, 2'b00);
      k = 0;
      while (!bus.out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("bp_reached_done", bus.out_valid, 1);
      repeat (5) @(negedge clk);
      bus.a = 8'h11; bus.b = 8'd1; bus.op = 2'b00; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      hold = 1'b0;
      drain();
      repeat (4) @(negedge clk);

      // Reset during SHIFT after the second step.
      @(negedge clk); issue(8'h3C, 8'd6, 2'b00);
      @(posedge clk);
      @(posedge clk);
      mon_en = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete(); exp_c_q.delete(); exp_z_q.delete();
      exp_lat_q.delete(); acc_q.delete();
      have_cur = 1'b0; was_taken = 1'b0;
      @(negedge clk);
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_out", bus.out, 0);
      check("abort_carry", bus.carry, 0);
      mon_en = 1'b1;
      @(negedge clk); issue(8'h3C, 8'd6, 2'b00);
      drain();

      // Random traffic with random consumer stalls.
      rnd = 1'b1;
      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] rb;
         case ($urandom_range(0, 3))
            0:       rb = W'($urandom_range(0, W - 1));
            1:       rb = W'($urandom_range(0, W));
            2:       rb = W'($urandom_range(W, 255));
            default: rb = W'($urandom);
         endcase
         @(negedge clk);
         issue(W'($urandom), rb, 2'($urandom_range(0, 3)));
      end
      drain();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised, multi-cycle shift/rotate unit for the ALU datapath. Successor to the 4-bit combinational left shifter.
- Generalises operand width and adds logical right, arithmetic right and rotate-left modes.
- Adds a carry-out (last bit shifted out) and a zero flag.
- Shifts iteratively, one bit position per clock, behind valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 8, operand and result width; power of two, >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the internal shift counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand.
- b  input  WIDTH  shift amount, unsigned.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- carry  output  1  last bit shifted or rotated out; 0 if no shift was performed.
- zero  output  1  high when out == 0; valid while out_valid is high.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - out=0, carry=0, zero=0, out_valid=0, in_ready=1.
  - Internal counter and operand registers are cleared.
  - Reset mid-operation aborts the operation with no result produced; any held result is discarded.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 (acceptance edge), capture a into the working register and op into the mode register, clear carry, and load the counter.
  - Counter for SLL/SRL/SRA: cnt = min(b, WIDTH). Any b >= WIDTH saturates to WIDTH.
  - Counter for ROL: cnt = b mod WIDTH, i.e. the low $clog2(WIDTH) bits of b.
  - If cnt == 0, go to DONE; otherwise go to SHIFT.
- State SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle performs one 1-bit step and decrements cnt.
  - SLL: carry <= w[W-1]; w <= {w[W-2:0],0}.
  - SRL: carry <= w[0]; w <= {0,w[W-1:1]}.
  - SRA: carry <= w[0]; w <= {w[W-1],w[W-1:1]}.
  - ROL: carry <= w[W-1]; w <= {w[W-2:0],w[W-1]}.
  - On the step where cnt reaches 0, go to DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - out, carry and zero hold stable until out_ready=1 is sampled at an edge, then return to IDLE.
  - out_valid deasserts in the following cycle.
  - No new request is accepted in the same cycle the result is consumed; the minimum issue interval is cnt+2 cycles.
- Latency:
  - out_valid rises cnt+1 clocks after the acceptance edge.
  - b=0 gives latency 1 with out=a.
  - Maximum latency is WIDTH+1.
- Width and saturation rules:
  - Logical shifts by >= WIDTH yield 0.
  - SRA by >= WIDTH yields all copies of a[W-1].
  - carry is defined by the step sequence above, including saturated counts.
- Request handling:
  - in_valid while in_ready=0 is ignored; the request must be held by the source.
  - a, b and op are sampled only at the acceptance edge.
  - op values are all defined; there is no illegal encoding.
- zero = (out == 0), registered together with out.

Test Plan:
- WIDTH=4, SLL, a=4'b1011, b=2 -> out=4'b1100, carry=0, zero=0; out_valid rises 3 clocks after acceptance.
- WIDTH=4, SLL, a=4'b1011, b=4 and then b=15 -> both give out=4'b0000, carry=1, zero=1, latency 5 (b saturated to 4).
- WIDTH=8, SRA, a=8'h90, b=3 -> out=8'hF2, carry=0. Then SRA a=8'h80, b=200 -> out=8'hFF, carry=1, latency 9.
- WIDTH=8, ROL, a=8'h81, b=9 -> effective count 1, out=8'h03, carry=1, latency 2. Then b=0, op=SRL, a=8'h5A -> out=8'h5A, carry=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out, carry and zero stable, in_ready=0. A second in_valid pulse during this window is not accepted. Raising out_ready gives IDLE in the next cycle.
- Assert rst for 1 cycle during SHIFT (WIDTH=8, SLL, b=6, after the 2nd step) -> next cycle in_ready=1, out_valid=0, out=0, carry=0. A fresh request then completes correctly.
